// File: rtl/fan_ramp_pwm.sv
// fan_ramp_pwm: single-fan PWM output stage.
// Turns a 0..127 percent command into a 100-step PWM waveform. Spin-up starts
// with a full-power kick, running duty never drops below a floor, and duty
// moves between levels one percent at a time. Duty and state only change on
// PWM period boundaries, so every output period is a clean single pulse.
module fan_ramp_pwm #(
    parameter int CLK_DIV      = 4,
    parameter int RAMP_PERIODS = 2,
    parameter int KICK_PERIODS = 8,
    parameter int MIN_RUN_PCT  = 20
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_percent,
    output logic       o_pwm,
    output logic [6:0] o_duty,
    output logic [1:0] o_state,
    output logic       o_period_start
);

    localparam int PW = $clog2(CLK_DIV) + 1;
    localparam int KW = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
    localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

    localparam logic [6:0]    MIN_DUTY   = 7'(MIN_RUN_PCT);
    localparam logic [6:0]    FULL_DUTY  = 7'd100;
    localparam logic [6:0]    LAST_COUNT = 7'd99;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [KW-1:0] KICK_LAST  = KW'(KICK_PERIODS - 1);
    localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_PERIODS - 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'b00,
        S_KICK = 2'b01,
        S_RAMP = 2'b10,
        S_HOLD = 2'b11
    } state_t;

    // Saturate the raw command to 0..100 and lift small non-zero requests to the run floor.
    function automatic logic [6:0] f_eff_target(input logic [6:0] pct);
        if (pct > FULL_DUTY)
            return FULL_DUTY;
        else if (pct == 7'd0)
            return 7'd0;
        else if (pct < MIN_DUTY)
            return MIN_DUTY;
        else
            return pct;
    endfunction

    // One percent move of the duty toward the goal.
    function automatic logic [6:0] f_step_toward(input logic [6:0] duty, input logic [6:0] goal);
        if (duty < goal)
            return duty + 7'd1;
        else if (duty > goal)
            return duty - 7'd1;
        else
            return duty;
    endfunction

    logic [PW-1:0] r_presc;
    logic [6:0]    r_count;
    logic [6:0]    r_tgt_p1;
    state_t        r_state;
    logic [6:0]    r_duty;
    logic [KW-1:0] r_kick_cnt;
    logic [RW-1:0] r_ramp_cnt;
    logic          r_pwm;
    logic          r_period_start;

    logic          w_tick;
    logic          w_boundary;
    logic [6:0]    w_count_next;
    logic [6:0]    w_goal;
    logic [6:0]    w_step;
    state_t        w_state_next;
    logic [6:0]    w_duty_next;
    logic [KW-1:0] w_kick_next;
    logic [RW-1:0] w_ramp_next;

    assign w_tick       = (r_presc == PRESC_LAST);
    assign w_boundary   = w_tick && (r_count == LAST_COUNT);
    assign w_count_next = w_tick ? ((r_count == LAST_COUNT) ? 7'd0 : r_count + 7'd1) : r_count;
    // A stopping fan ramps down to the floor before being switched off.
    assign w_goal       = (r_tgt_p1 != 7'd0) ? r_tgt_p1 : MIN_DUTY;
    assign w_step       = f_step_toward(r_duty, w_goal);

    // Prescaler and 0..99 PWM counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
            r_count <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            r_count <= w_count_next;
        end
    end

    // Effective target, one register stage after the raw command.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_tgt_p1 <= '0;
        else
            r_tgt_p1 <= f_eff_target(i_percent);
    end

    // State, duty and period counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_OFF;
            r_duty     <= '0;
            r_kick_cnt <= '0;
            r_ramp_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_duty     <= w_duty_next;
            r_kick_cnt <= w_kick_next;
            r_ramp_cnt <= w_ramp_next;
        end
    end

    // Next state and duty, evaluated only on the period boundary.
    always_comb begin
        w_state_next = r_state;
        w_duty_next  = r_duty;
        w_kick_next  = r_kick_cnt;
        w_ramp_next  = r_ramp_cnt;
        if (w_boundary) begin
            case (r_state)
                S_OFF: begin
                    if (r_tgt_p1 != 7'd0) begin
                        w_state_next = S_KICK;
                        w_duty_next  = FULL_DUTY;
                        w_kick_next  = '0;
                    end
                end
                S_KICK: begin
                    if (r_tgt_p1 == 7'd0) begin
                        w_state_next = S_OFF;
                        w_duty_next  = 7'd0;
                    end else if (r_kick_cnt == KICK_LAST) begin
                        w_duty_next  = MIN_DUTY;
                        w_ramp_next  = '0;
                        w_state_next = (r_tgt_p1 == MIN_DUTY) ? S_HOLD : S_RAMP;
                    end else begin
                        w_kick_next = r_kick_cnt + KW'(1);
                    end
                end
                S_RAMP: begin
                    if (r_duty == w_goal) begin
                        if (r_tgt_p1 == 7'd0) begin
                            w_state_next = S_OFF;
                            w_duty_next  = 7'd0;
                        end else begin
                            w_state_next = S_HOLD;
                        end
                    end else if (r_ramp_cnt == RAMP_LAST) begin
                        w_duty_next = w_step;
                        w_ramp_next = '0;
                        if ((w_step == w_goal) && (r_tgt_p1 != 7'd0))
                            w_state_next = S_HOLD;
                    end else begin
                        w_ramp_next = r_ramp_cnt + RW'(1);
                    end
                end
                S_HOLD: begin
                    if (r_tgt_p1 != r_duty) begin
                        w_state_next = S_RAMP;
                        w_ramp_next  = '0;
                    end
                end
                default: begin
                    w_state_next = S_OFF;
                    w_duty_next  = 7'd0;
                end
            endcase
        end
    end

    // Registered PWM pin and period-start pulse, aligned with the count and duty they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_pwm          <= (w_count_next < w_duty_next);
            r_period_start <= w_boundary;
        end
    end

    assign o_pwm          = r_pwm;
    assign o_duty         = r_duty;
    assign o_state        = r_state;
    assign o_period_start = r_period_start;

endmodule
